// File: rtl/phaser_ctrl_pkg.sv
// Shared widths, opcodes and FSM state encoding for the PHASER_OUT
// dynamic-delay tap controller.
package phaser_ctrl_pkg;

  localparam int unsigned FINE_W   = 6;
  localparam int unsigned COARSE_W = 3;
  localparam int unsigned CNT_W    = 9;
  localparam int unsigned TMR_W    = 8;

  localparam logic [1:0] OP_SET_FINE   = 2'd0;
  localparam logic [1:0] OP_SET_COARSE = 2'd1;
  localparam logic [1:0] OP_LOAD       = 2'd2;
  localparam logic [1:0] OP_READ       = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STEP,
    ST_SETTLE,
    ST_LOAD,
    ST_RDWAIT,
    ST_FIN
  } state_e;

endpackage

// File: rtl/phaser_settle_timer.sv
// Loadable down-counter shared by the settle gap and the counter read wait.
// expire_o is high during the last cycle of a loaded interval.
module phaser_settle_timer
  import phaser_ctrl_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [TMR_W-1:0] load_i,
  output logic             expire_o
);

  logic [TMR_W-1:0] cnt_q;
  logic [TMR_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start_i) begin
      cnt_d = load_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - TMR_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == TMR_W'(1));

endmodule

// File: rtl/phaser_out_tap_ctrl.sv
// Command sequencer for one PHASER_OUT dynamic-delay port: converts set-tap
// commands into single-tap pulses with settle gaps and tracks tap positions.
module phaser_out_tap_ctrl
  import phaser_ctrl_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 8,
  parameter int unsigned READ_LAT      = 2,
  parameter int unsigned FINE_INIT     = 0,
  parameter int unsigned COARSE_INIT   = 0
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       REQVALID,
  output logic       REQREADY,
  input  logic [1:0] REQOP,
  input  logic [8:0] REQDATA,
  output logic       DONE,
  output logic       ERR,
  output logic [8:0] RDATA,
  output logic [5:0] FINETAP,
  output logic [2:0] COARSETAP,
  output logic       FINEENABLE,
  output logic       FINEINC,
  output logic       COARSEENABLE,
  output logic       COARSEINC,
  output logic       COUNTERLOADEN,
  output logic [8:0] COUNTERLOADVAL,
  output logic       COUNTERREADEN,
  input  logic [8:0] COUNTERREADVAL,
  input  logic       FINEOVERFLOW,
  input  logic       COARSEOVERFLOW
);

  localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE_CYCLES);
  localparam logic [TMR_W-1:0] RD_LD     = TMR_W'(READ_LAT + 1);

  state_e               state_q, state_d;
  logic [1:0]           op_q, op_d;
  logic [CNT_W-1:0]     tgt_q, tgt_d;
  logic [FINE_W-1:0]    fine_q, fine_d;
  logic [COARSE_W-1:0]  coarse_q, coarse_d;
  logic                 ready_q, ready_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 fen_q, fen_d;
  logic                 finc_q, finc_d;
  logic                 cen_q, cen_d;
  logic                 cinc_q, cinc_d;
  logic                 lden_q, lden_d;
  logic [CNT_W-1:0]     ldval_q, ldval_d;
  logic                 rden_q, rden_d;
  logic [CNT_W-1:0]     rdata_q, rdata_d;

  logic [1:0]           sel_op;
  logic [CNT_W-1:0]     sel_tgt;
  logic                 sel_fine;
  logic [CNT_W-1:0]     cur_pos;
  logic                 ovf;
  logic                 bad_tgt;
  logic                 fin_err;
  logic                 step_nx;
  logic                 inc_nx;
  logic                 tmr_start;
  logic [TMR_W-1:0]     tmr_load;
  logic                 tmr_expire;

  phaser_settle_timer u_timer (
    .clk_i    (CLK),
    .rst_i    (RST),
    .start_i  (tmr_start),
    .load_i   (tmr_load),
    .expire_o (tmr_expire)
  );

  // In IDLE the live request is decoded; afterwards the registered command.
  always_comb begin
    sel_op   = (state_q == ST_IDLE) ? REQOP : op_q;
    sel_tgt  = (state_q == ST_IDLE) ? REQDATA : tgt_q;
    sel_fine = (sel_op == OP_SET_FINE);
    cur_pos  = sel_fine ? CNT_W'(fine_q) : CNT_W'(coarse_q);
    bad_tgt  = sel_fine ? (REQDATA[8:6] != '0) : (REQDATA[8:3] != '0);
    ovf      = (op_q == OP_SET_FINE) ? FINEOVERFLOW : COARSEOVERFLOW;
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    tgt_d     = tgt_q;
    fin_err   = 1'b0;
    tmr_start = 1'b0;
    tmr_load  = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (REQVALID && ready_q) begin
          op_d  = REQOP;
          tgt_d = REQDATA;
          if (REQOP == OP_LOAD) begin
            state_d = ST_LOAD;
          end else if (REQOP == OP_READ) begin
            state_d   = ST_RDWAIT;
            tmr_start = 1'b1;
            tmr_load  = RD_LD;
          end else if (bad_tgt) begin
            state_d = ST_FIN;
            fin_err = 1'b1;
          end else if (REQDATA == cur_pos) begin
            state_d = ST_FIN;
          end else begin
            state_d = ST_STEP;
          end
        end
      end
      ST_STEP: begin
        state_d   = ST_SETTLE;
        tmr_start = 1'b1;
        tmr_load  = SETTLE_LD;
      end
      ST_SETTLE: begin
        if (ovf) begin
          state_d = ST_FIN;
          fin_err = 1'b1;
        end else if (tmr_expire) begin
          state_d = (tgt_q == cur_pos) ? ST_FIN : ST_STEP;
        end
      end
      ST_LOAD:   state_d = ST_FIN;
      ST_RDWAIT: if (tmr_expire) state_d = ST_FIN;
      ST_FIN:    state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so each pulse lines up with
  // the cycle its state occupies; tracking follows the pulse actually issued.
  always_comb begin
    step_nx = (state_d == ST_STEP);
    inc_nx  = (sel_tgt > cur_pos);
    fen_d   = step_nx && sel_fine;
    finc_d  = fen_d && inc_nx;
    cen_d   = step_nx && !sel_fine;
    cinc_d  = cen_d && inc_nx;
    lden_d  = (state_d == ST_LOAD);
    ldval_d = ((state_q == ST_IDLE) && (state_d == ST_LOAD)) ? REQDATA : ldval_q;
    rden_d  = (state_q == ST_IDLE) && (state_d == ST_RDWAIT);
    rdata_d = ((state_q == ST_RDWAIT) && tmr_expire) ? COUNTERREADVAL : rdata_q;
    ready_d = (state_d == ST_IDLE);
    done_d  = (state_d == ST_FIN);
    err_d   = fin_err;

    fine_d   = fine_q;
    coarse_d = coarse_q;
    if (fen_q) begin
      fine_d = finc_q ? (fine_q + FINE_W'(1)) : (fine_q - FINE_W'(1));
    end
    if (cen_q) begin
      coarse_d = cinc_q ? (coarse_q + COARSE_W'(1)) : (coarse_q - COARSE_W'(1));
    end
    if (lden_q) begin
      fine_d   = ldval_q[5:0];
      coarse_d = ldval_q[8:6];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_SET_FINE;
      tgt_q    <= '0;
      fine_q   <= FINE_W'(FINE_INIT);
      coarse_q <= COARSE_W'(COARSE_INIT);
      ready_q  <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      fen_q    <= 1'b0;
      finc_q   <= 1'b0;
      cen_q    <= 1'b0;
      cinc_q   <= 1'b0;
      lden_q   <= 1'b0;
      ldval_q  <= '0;
      rden_q   <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      tgt_q    <= tgt_d;
      fine_q   <= fine_d;
      coarse_q <= coarse_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
      err_q    <= err_d;
      fen_q    <= fen_d;
      finc_q   <= finc_d;
      cen_q    <= cen_d;
      cinc_q   <= cinc_d;
      lden_q   <= lden_d;
      ldval_q  <= ldval_d;
      rden_q   <= rden_d;
      rdata_q  <= rdata_d;
    end
  end

  assign REQREADY       = ready_q;
  assign DONE           = done_q;
  assign ERR            = err_q;
  assign RDATA          = rdata_q;
  assign FINETAP        = fine_q;
  assign COARSETAP      = coarse_q;
  assign FINEENABLE     = fen_q;
  assign FINEINC        = finc_q;
  assign COARSEENABLE   = cen_q;
  assign COARSEINC      = cinc_q;
  assign COUNTERLOADEN  = lden_q;
  assign COUNTERLOADVAL = ldval_q;
  assign COUNTERREADEN  = rden_q;

endmodule
